// File: rtl/nonogram_pkg.sv
// Shared types and helpers for the nonogram solver I/O path.
// Consumed by board_serializer and row_byte_select.
package nonogram_pkg;

    localparam int DEFAULT_MAX_ROWS = 16;
    localparam int DEFAULT_MAX_COLS = 16;

    typedef enum logic [2:0] {
        IDLE,
        HDR_ROWS,
        HDR_COLS,
        ROW_DATA,
        CHECKSUM
    } ser_state_t;

    // Number of packed bytes needed to carry one row of the given width.
    function automatic int bytes_per_row(input int cols);
        return (cols + 7) / 8;
    endfunction

endpackage

// File: rtl/row_byte_select.sv
// Combinational extraction of byte k of row r from a board snapshot.
// Columns at or beyond n_cols read back as 0.
module row_byte_select
    import nonogram_pkg::*;
#(
    parameter int MAX_ROWS = DEFAULT_MAX_ROWS,
    parameter int MAX_COLS = DEFAULT_MAX_COLS,
    parameter int DIM_W    = 5
) (
    input  logic [MAX_ROWS*MAX_COLS-1:0] snapshot,
    input  logic [DIM_W-1:0]             row,
    input  logic [DIM_W-1:0]             byte_idx,
    input  logic [DIM_W-1:0]             n_cols,
    output logic [7:0]                   byte_val
);

    logic [7:0] window;
    int         base;

    // Bits that spill past the row end are always >= n_cols, so the mask covers them.
    always_comb begin
        base     = int'(row) * MAX_COLS + int'(byte_idx) * 8;
        window   = 8'(snapshot >> base);
        byte_val = '0;
        for (int j = 0; j < 8; j++) begin
            byte_val[j] = window[j] && ((int'(byte_idx) * 8 + j) < int'(n_cols));
        end
    end

endmodule

// File: rtl/board_serializer.sv
// Snapshots a solved m x n board and streams header, packed rows and an
// optional XOR checksum byte (enabled by BOARD_SERIALIZER_CHECKSUM_EN).
module board_serializer
    import nonogram_pkg::*;
#(
    parameter int MAX_ROWS = DEFAULT_MAX_ROWS,
    parameter int MAX_COLS = DEFAULT_MAX_COLS,
    parameter int DIM_W    = $clog2(((MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS) + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [MAX_ROWS*MAX_COLS-1:0] solution,
    input  logic [DIM_W-1:0]             n,
    input  logic [DIM_W-1:0]             m,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [7:0]                   byte_out,
    output logic                         busy,
    output logic                         frame_done
);

    ser_state_t                   state;
    ser_state_t                   state_next;
    ser_state_t                   tail_state;
    logic [MAX_ROWS*MAX_COLS-1:0] snapshot;
    logic [DIM_W-1:0]             rows_q;
    logic [DIM_W-1:0]             cols_q;
    logic [DIM_W-1:0]             row_cnt;
    logic [DIM_W-1:0]             byte_cnt;
    logic [7:0]                   row_byte;
    logic                         xfer;
    logic                         last_byte_of_row;
    logic                         last_row;
    logic                         dims_zero;
`ifdef BOARD_SERIALIZER_CHECKSUM_EN
    logic [7:0]                   chk;
    assign tail_state = CHECKSUM;
`else
    assign tail_state = IDLE;
`endif

    assign out_valid        = (state != IDLE);
    assign busy             = (state != IDLE);
    assign xfer             = out_valid & out_ready;
    assign last_byte_of_row = (int'(byte_cnt) == bytes_per_row(int'(cols_q)) - 1);
    assign last_row         = (row_cnt == rows_q - 1'b1);
    assign dims_zero        = (rows_q == '0) || (cols_q == '0);

    row_byte_select #(
        .MAX_ROWS (MAX_ROWS),
        .MAX_COLS (MAX_COLS),
        .DIM_W    (DIM_W)
    ) u_row_byte_select (
        .snapshot (snapshot),
        .row      (row_cnt),
        .byte_idx (byte_cnt),
        .n_cols   (cols_q),
        .byte_val (row_byte)
    );

    // byte_out is a pure function of held state, so it stays put during stalls.
    always_comb begin
        byte_out = 8'h00;
        case (state)
            HDR_ROWS: byte_out = 8'(rows_q);
            HDR_COLS: byte_out = 8'(cols_q);
            ROW_DATA: byte_out = row_byte;
`ifdef BOARD_SERIALIZER_CHECKSUM_EN
            CHECKSUM: byte_out = chk;
`endif
            default:  byte_out = 8'h00;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (valid_in) state_next = HDR_ROWS;
            HDR_ROWS: if (xfer) state_next = HDR_COLS;
            HDR_COLS: if (xfer) state_next = dims_zero ? tail_state : ROW_DATA;
            ROW_DATA: if (xfer && last_byte_of_row && last_row) state_next = tail_state;
            CHECKSUM: if (xfer) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            snapshot   <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            row_cnt    <= '0;
            byte_cnt   <= '0;
            frame_done <= 1'b0;
`ifdef BOARD_SERIALIZER_CHECKSUM_EN
            chk        <= 8'h00;
`endif
        end else begin
            state      <= state_next;
            frame_done <= (state != IDLE) && (state_next == IDLE);
            if (state == IDLE && valid_in) begin
                snapshot <= solution;
                rows_q   <= (int'(m) > MAX_ROWS) ? DIM_W'(MAX_ROWS) : m;
                cols_q   <= (int'(n) > MAX_COLS) ? DIM_W'(MAX_COLS) : n;
                row_cnt  <= '0;
                byte_cnt <= '0;
`ifdef BOARD_SERIALIZER_CHECKSUM_EN
                chk      <= 8'h00;
`endif
            end
`ifdef BOARD_SERIALIZER_CHECKSUM_EN
            if (xfer) begin
                chk <= chk ^ byte_out;
            end
`endif
            // Byte-in-row wraps and the row advances on the last byte of each row.
            if (state == ROW_DATA && xfer) begin
                if (last_byte_of_row) begin
                    byte_cnt <= '0;
                    row_cnt  <= row_cnt + 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_serializer.sv
// Directed self-checking bench for board_serializer (16x16 build).
// Honours BOARD_SERIALIZER_CHECKSUM_EN for the expected trailing byte.
module tb_board_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic [255:0] solution = '0;
    logic [4:0]   n = '0;
    logic [4:0]   m = '0;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [7:0]   byte_out;
    logic         busy;
    logic         frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   got_q[$];
    logic [7:0]   exp_q[$];
    int           done_cycles;
    bit           timed_out;
    int           stall_err;
    logic         done_busy;
    logic         done_valid;
    logic [255:0] alt_sol;
    logic [4:0]   alt_m;
    logic [4:0]   alt_n;
    logic [255:0] chain_sol;
    logic [4:0]   chain_m;
    logic [4:0]   chain_n;

    board_serializer #(
        .MAX_ROWS (16),
        .MAX_COLS (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .solution   (solution),
        .n          (n),
        .m          (m),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .byte_out   (byte_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] board_of(input int rows, input logic [15:0] even_row,
                                               input logic [15:0] odd_row);
        logic [255:0] b;
        b = '0;
        for (int r = 0; r < rows; r++) begin
            b[r*16 +: 16] = (r % 2 == 0) ? even_row : odd_row;
        end
        return b;
    endfunction

    task automatic add_checksum();
`ifdef BOARD_SERIALIZER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`endif
    endtask

    task automatic start_frame(input logic [255:0] sol, input logic [4:0] rows, input logic [4:0] cols);
        @(negedge clk);
        solution = sol;
        m        = rows;
        n        = cols;
        valid_in = 1'b1;
    endtask

    // Collects transferred bytes until frame_done; optionally pulses valid_in mid-frame
    // and/or starts a chained frame in the frame_done cycle.
    task automatic collect_frame(input bit rand_ready, input int mid_pulse, input bit chain);
        bit         prev_stall;
        logic [7:0] prev_byte;
        got_q.delete();
        stall_err  = 0;
        timed_out  = 1'b1;
        prev_stall = 1'b0;
        prev_byte  = 8'h00;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            valid_in = 1'b0;
            if (prev_stall && (out_valid !== 1'b1 || byte_out !== prev_byte)) stall_err++;
            if (frame_done === 1'b1) begin
                done_cycles = cyc;
                done_busy   = busy;
                done_valid  = out_valid;
                timed_out   = 1'b0;
                if (chain) begin
                    solution = chain_sol;
                    m        = chain_m;
                    n        = chain_n;
                    valid_in = 1'b1;
                end
                break;
            end
            if (cyc == mid_pulse) begin
                solution = alt_sol;
                m        = alt_m;
                n        = alt_n;
                valid_in = 1'b1;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid === 1'b1 && out_ready) got_q.push_back(byte_out);
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_byte  = byte_out;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done: got %b expected 0", frame_done); end
        checks++; if (byte_out !== 8'h00) begin errors++; $display("[TB] FAIL rst_byte_out: got %02h expected 00", byte_out); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_5x5();
        int exp_cyc;
        exp_q = '{8'h05, 8'h05, 8'h15, 8'h0A, 8'h15, 8'h0A, 8'h15};
        add_checksum();
        exp_cyc = 8;
`ifdef BOARD_SERIALIZER_CHECKSUM_EN
        exp_cyc = 9;
`endif
        start_frame(board_of(5, 16'h0015, 16'h000A), 5'd5, 5'd5);
        collect_frame(1'b0, -1, 1'b0);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL t5x5_timeout: got no frame_done expected frame_done"); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL t5x5_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL t5x5_byte%0d: got %02h expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++; if (done_cycles != exp_cyc) begin errors++; $display("[TB] FAIL t5x5_done_cycle: got %0d expected %0d", done_cycles, exp_cyc); end
        checks++; if (done_busy !== 1'b0 || done_valid !== 1'b0) begin errors++; $display("[TB] FAIL t5x5_done_idle: got busy=%b valid=%b expected 0 0", done_busy, done_valid); end
    endtask

    task automatic test_legacy_11x11();
        exp_q = '{8'h0B, 8'h0B};
        for (int r = 0; r < 11; r++) begin
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'h07);
        end
        add_checksum();
        start_frame(board_of(11, 16'h07FF, 16'h07FF), 5'd11, 5'd11);
        collect_frame(1'b0, -1, 1'b0);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL t11_timeout: got no frame_done expected frame_done"); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL t11_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL t11_byte%0d: got %02h expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_padding_stalls();
        exp_q = '{8'h02, 8'h09, 8'hFF, 8'h01, 8'h3C, 8'h01};
        add_checksum();
        start_frame(board_of(2, 16'hFFFF, 16'hAB3C), 5'd2, 5'd9);
        collect_frame(1'b1, -1, 1'b0);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL tpad_timeout: got no frame_done expected frame_done"); end
        checks++; if (stall_err != 0) begin errors++; $display("[TB] FAIL tpad_stall_stable: got %0d unstable stalls expected 0", stall_err); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL tpad_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL tpad_byte%0d: got %02h expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_clamp();
        exp_q = '{8'h01, 8'h10, 8'h34, 8'h12};
        add_checksum();
        start_frame(board_of(1, 16'h1234, 16'h0000), 5'd1, 5'd20);
        collect_frame(1'b0, -1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL tclampn_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL tclampn_byte%0d: got %02h expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        exp_q = '{8'h10, 8'h01};
        for (int r = 0; r < 16; r++) exp_q.push_back((r % 2 == 0) ? 8'h01 : 8'h00);
        add_checksum();
        start_frame(board_of(16, 16'h0001, 16'h0000), 5'd20, 5'd1);
        collect_frame(1'b0, -1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL tclampm_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL tclampm_byte%0d: got %02h expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_cyc;
        alt_sol   = board_of(16, 16'hFFFF, 16'hFFFF);
        alt_m     = 5'd9;
        alt_n     = 5'd9;
        chain_sol = board_of(2, 16'hFFFF, 16'hFFFF);
        chain_m   = 5'd2;
        chain_n   = 5'd3;
        exp_q = '{8'h05, 8'h05, 8'h15, 8'h0A, 8'h15, 8'h0A, 8'h15};
        add_checksum();
        start_frame(board_of(5, 16'h0015, 16'h000A), 5'd5, 5'd5);
        collect_frame(1'b0, 3, 1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL tb2b_first_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL tb2b_first_byte%0d: got %02h expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        exp_q = '{8'h02, 8'h03, 8'h07, 8'h07};
        add_checksum();
        exp_cyc = 5;
`ifdef BOARD_SERIALIZER_CHECKSUM_EN
        exp_cyc = 6;
`endif
        collect_frame(1'b0, -1, 1'b0);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL tb2b_second_timeout: got no frame_done expected frame_done"); end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL tb2b_second_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL tb2b_second_byte%0d: got %02h expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++; if (done_cycles != exp_cyc) begin errors++; $display("[TB] FAIL tb2b_second_done_cycle: got %0d expected %0d", done_cycles, exp_cyc); end
    endtask

    task automatic test_mid_reset();
        start_frame(board_of(11, 16'h07FF, 16'h07FF), 5'd11, 5'd11);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            valid_in  = 1'b0;
            out_ready = 1'b1;
        end
        checks++; if (byte_out !== 8'h07 || busy !== 1'b1) begin errors++; $display("[TB] FAIL tmidrst_pre: got byte=%02h busy=%b expected 07 1", byte_out, busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL tmidrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL tmidrst_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL tmidrst_frame_done: got %b expected 0", frame_done); end
        checks++; if (byte_out !== 8'h00) begin errors++; $display("[TB] FAIL tmidrst_byte_out: got %02h expected 00", byte_out); end
        @(negedge clk);
        rst = 1'b0;
        exp_q = '{8'h05, 8'h05, 8'h15, 8'h0A, 8'h15, 8'h0A, 8'h15};
        add_checksum();
        start_frame(board_of(5, 16'h0015, 16'h000A), 5'd5, 5'd5);
        collect_frame(1'b0, -1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL tmidrst_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL tmidrst_byte%0d: got %02h expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_dims();
        exp_q = '{8'h00, 8'h07};
        add_checksum();
        start_frame(board_of(16, 16'hFFFF, 16'hFFFF), 5'd0, 5'd7);
        collect_frame(1'b0, -1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL tzero_m_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL tzero_m_byte%0d: got %02h expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        exp_q = '{8'h03, 8'h00};
        add_checksum();
        start_frame(board_of(16, 16'hFFFF, 16'hFFFF), 5'd3, 5'd0);
        collect_frame(1'b0, -1, 1'b0);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL tzero_n_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("[TB] FAIL tzero_n_byte%0d: got %02h expected %02h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    initial begin
        $display("[TB] board_serializer bench start");
        test_reset();
        test_5x5();
        test_legacy_11x11();
        test_padding_stalls();
        test_clamp();
        test_back_to_back();
        test_mid_reset();
        test_zero_dims();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_serializer.md
Name: board_serializer

Overview:
Parametrised solution-to-byte-stream serializer between the solver and uart_tx. It replaces the fixed 11x11 assembler.
- Snapshots a solved board of runtime size m rows x n cols, up to MAX_ROWS x MAX_COLS.
- Emits a framed byte stream under a valid/ready handshake: size header, packed row bytes, optional checksum.

Parameters:
MAX_ROWS, 16, maximum board rows supported (1..255)
MAX_COLS, 16, maximum board columns supported (1..255)
DIM_W, $clog2(max(MAX_ROWS,MAX_COLS)+1), width of runtime dimension inputs (derived; do not override)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
valid_in  in  1  one-cycle pulse: solution, n, m valid; start frame
solution  in  MAX_ROWS*MAX_COLS  bit r*MAX_COLS+c = cell (row r, col c); 1 = filled
n  in  DIM_W  runtime column count
m  in  DIM_W  runtime row count
out_ready  in  1  downstream accepts byte_out this cycle (tie to uart_tx idle)
out_valid  out  1  byte_out holds a valid byte
byte_out  out  8  stream byte
busy  out  1  frame in progress; valid_in ignored
frame_done  out  1  one-cycle pulse after the final byte handshake

Behaviour:
- Reset (async, any state): state IDLE, out_valid=0, byte_out=0, busy=0, frame_done=0, snapshot and counters cleared. An in-flight frame is abandoned with no partial tail.
- IDLE, valid_in=1 at cycle t:
  - register solution, n, m and clamp n to MAX_COLS, m to MAX_ROWS;
  - busy=1 from t+1;
  - out_valid=1 with header byte 0 at t+1.
- Frame order:
  - HDR_ROWS: byte = m (zero-extended to 8 bits).
  - HDR_COLS: byte = n.
  - ROW_DATA: for r=0..m-1, k=0..ceil(n/8)-1, byte bit j = cell(r, 8k+j). Columns >= n are 0.
  - CHECKSUM: only when the optional feature is enabled.
  - Then back to IDLE.
- Byte count = 2 + m*ceil(n/8) (+1 with checksum).
- Handshake:
  - A byte transfers on out_valid & out_ready.
  - While out_valid & !out_ready, byte_out and state hold stable.
  - The next byte is presented the cycle after a transfer. Back-to-back transfers are allowed, one byte per cycle when out_ready is held high.
- Counters: row counter and byte-in-row counter. Byte-in-row wraps to 0 and the row counter increments on the last byte of a row. Move to CHECKSUM/IDLE after the last byte of row m-1.
- Zero dimensions: m=0 or n=0 -> header bytes only, then the checksum if enabled. ROW_DATA is skipped.
- valid_in while busy: ignored. The snapshot is not overwritten.
- valid_in in the same cycle as frame_done: busy is already 0, so it is accepted and the new frame starts next cycle.
- End of frame:
  - busy falls in the cycle after the final transfer; frame_done pulses in that same cycle.
  - out_valid=0 in IDLE.
- Solution input need only be stable in the valid_in cycle.

Optional Feature:
BOARD_SERIALIZER_CHECKSUM_EN:
- Defined: a trailing byte equal to the XOR of all preceding frame bytes (header included) is sent in state CHECKSUM. The running XOR updates on each transfer and clears on frame start.
- Undefined: no CHECKSUM state, no XOR register, and the frame ends after the last row byte.

Decomposition:
Package nonogram_pkg holds:
- MAX_ROWS/MAX_COLS defaults;
- the ser_state_t enum (IDLE, HDR_ROWS, HDR_COLS, ROW_DATA, CHECKSUM);
- a bytes_per_row(n) function, ceil(n/8).

One sub-module, row_byte_select: a combinational mux that extracts byte k of row r from the snapshot and masks columns >= n. The parser and future debug readback reuse it.

Test Plan:
1. 5x5 board, row r = 5'b10101 >> (r%2), out_ready=1: bytes 05,05,15,0A,15,0A,15; frame_done 8 cycles after valid_in.
2. 11x11 legacy board, all filled: 0B,0B, then 11 pairs FF,07; total 24 bytes.
3. n=9, m=2, cells with col>=9 set in the snapshot: padding bits read 0 (row bytes xx,01 max); out_ready toggles randomly, and byte_out stays stable during stalls with no byte lost or duplicated.
4. valid_in pulsed mid-frame with a different board: ignored, original frame completes intact; a pulse coincident with frame_done starts a second frame.
5. rst asserted mid-ROW_DATA: out_valid, busy, frame_done, byte_out all 0 immediately (async); the next valid_in produces a full fresh frame from the header.
6. m=0, n=7, checksum enabled: bytes 00,07,07 (XOR); without the macro: 00,07 only.
